// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Narrower data words are zero-extended by the caller; this leaves the XOR unchanged.
  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 16x oversampled framing with a one-entry holding buffer
// for back-to-back frames and optional parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // Bit periods use the low 4 bits; the counter widens only when a long stop bit needs it.
  localparam int TICK_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DBIT_LAST = BIT_W'(DBIT - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  uart_state_e       state_q;
  logic [TICK_W-1:0] tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DBIT-1:0]   shreg_q;
  logic [DBIT-1:0]   buf_q;
  logic              buf_full_q;
  logic              parity_q;
  logic              tx_q;
  logic              done_q;

  logic              accept;
  logic              stop_end;
  logic [DBIT-1:0]   load_d;
  logic              parity_d;

  assign accept   = tx_start && !buf_full_q;
  assign stop_end = (state_q == STOP) && s_tick && (tick_q == STOP_LAST);
  // A buffered byte always wins; otherwise a request arriving right now is loaded directly.
  assign load_d   = buf_full_q ? buf_q : tx_din;
  assign parity_d = parity_of(8'(load_d), PAR_ODD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && (state_q != IDLE) && !stop_end) begin
        buf_q      <= tx_din;
        buf_full_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q  <= tx_din;
            parity_q <= parity_d;
            tick_q   <= '0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shreg_q[0];
              state_q <= DATA;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              shreg_q <= shreg_q >> 1;
              if (bit_q == DBIT_LAST) begin
                if (PARITY_EN != 0) begin
                  tx_q    <= parity_q;
                  state_q <= PARITY;
                end else begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
                end
              end else begin
                bit_q <= bit_q + 1'b1;
                tx_q  <= shreg_q[1];
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q <= '0;
              done_q <= 1'b1;
              // Chain straight into the next start bit so no idle-high gap appears.
              if (buf_full_q || accept) begin
                shreg_q    <= load_d;
                parity_q   <= parity_d;
                buf_full_q <= 1'b0;
                tx_q       <= 1'b0;
                state_q    <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready     = !buf_full_q;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five parameterisations checked against an
// expected line waveform built per s_tick period from the frame format.
module tb_uart_tx;

  localparam int NINST = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       tx_start_w [NINST];
  logic [7:0] tx_din_w   [NINST];
  logic       tx_w       [NINST];
  logic       ready_w    [NINST];
  logic       busy_w     [NINST];
  logic       done_w     [NINST];

  int tests = 0;
  int fails = 0;
  int cur_k = 0;

  // Expected line level per s_tick period: bit 0 = level, value 2 added on a frame's last period.
  int exp_q[$];
  int dir_q[$];
  int outstanding = 0;
  bit done_pending = 1'b0;
  int cur_idx = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  uart_tx u_def (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start_w[0]), .tx_din(tx_din_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start_w[1]), .tx_din(tx_din_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start_w[2]), .tx_din(tx_din_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));

  uart_tx #(.SB_TICK(32)) u_sb32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start_w[3]), .tx_din(tx_din_w[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]));

  uart_tx #(.DBIT(5), .SB_TICK(24)) u_d5 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start_w[4]), .tx_din(tx_din_w[4][4:0]),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done_tick(done_w[4]));

  function automatic int dbit_of(input int k);
    return (k == 4) ? 5 : 8;
  endfunction

  function automatic int sb_of(input int k);
    return (k == 3) ? 32 : ((k == 4) ? 24 : 16);
  endfunction

  function automatic int pen_of(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int odd_of(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int k);
    return (1 + dbit_of(k) + pen_of(k)) * 16 + sb_of(k);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s (inst %0d, t=%0t): got %0d, expected %0d", tag, cur_k, $time, got, exp);
    end
  endtask

  task automatic push_frame(input int k, input int d);
    int ones = 0;
    int b;
    int p;
    repeat (16) exp_q.push_back(0);
    for (int i = 0; i < dbit_of(k); i++) begin
      b = (d >> i) & 1;
      ones += b;
      repeat (16) exp_q.push_back(b);
    end
    if (pen_of(k) != 0) begin
      p = (odd_of(k) != 0) ? (1 - (ones % 2)) : (ones % 2);
      repeat (16) exp_q.push_back(p);
    end
    repeat (sb_of(k) - 1) exp_q.push_back(1);
    exp_q.push_back(3);
  endtask

  task automatic run_phase(input int k, input int ncyc, input int pct, input int rst_idx,
                           input bit gap_chk, output int frames_done, output int done_seen);
    int  cyc = 0;
    int  last_dt = -1;
    int  popped;
    int  d;
    bit  go;
    bit  rst_armed;
    rst_armed = (rst_idx >= 0);
    frames_done = 0;
    done_seen = 0;
    cur_k = k;
    while (cyc < ncyc || ((exp_q.size() != 0 || done_pending) && cyc < ncyc + 20000)) begin
      @(negedge clk);
      reset_n = 1'b1;
      tx_start_w[k] = 1'b0;
      s_tick = 1'($urandom_range(0, 1));
      check("busy", busy_w[k], (exp_q.size() != 0) ? 1 : 0);
      check("done", done_w[k], done_pending ? 1 : 0);
      if (done_w[k]) begin
        done_seen++;
        if (gap_chk && last_dt >= 0) check("done_gap", tick_cnt - last_dt, frame_len(k));
        last_dt = tick_cnt;
      end
      done_pending = 1'b0;
      check("ready", ready_w[k], (outstanding < 2) ? 1 : 0);
      check("tx", tx_w[k], (exp_q.size() != 0) ? (exp_q[0] & 1) : 1);
      popped = -1;
      if (s_tick) begin
        tick_cnt++;
        if (exp_q.size() != 0) begin
          popped = exp_q.pop_front();
          cur_idx++;
        end
      end
      if (rst_armed && outstanding > 0 && cur_idx >= rst_idx) begin
        reset_n = 1'b0;
        exp_q.delete();
        outstanding = 0;
        cur_idx = 0;
        rst_armed = 1'b0;
      end else begin
        go = 1'b0;
        d = 0;
        if (cyc < ncyc) begin
          if (dir_q.size() != 0) begin
            if ($urandom_range(0, 9) == 0) begin
              d = dir_q.pop_front();
              go = 1'b1;
            end
          end else if (pct > 0 && $urandom_range(0, 99) < pct) begin
            d = int'($urandom_range(0, 255));
            go = 1'b1;
          end
        end
        if (go) begin
          tx_start_w[k] = 1'b1;
          tx_din_w[k] = 8'(d);
          if (outstanding < 2) begin
            push_frame(k, d);
            outstanding++;
          end
        end
        if (popped >= 2) begin
          outstanding--;
          done_pending = 1'b1;
          cur_idx = 0;
          frames_done++;
        end
      end
      cyc++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 1, 0);
    check("done_cnt", done_seen, frames_done);
  endtask

  initial begin
    int fr;
    int dn;
    reset_n = 1'b0;
    s_tick = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      tx_start_w[i] = 1'b0;
      tx_din_w[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      cur_k = i;
      check("rst_tx", tx_w[i], 1);
      check("rst_ready", ready_w[i], 1);
      check("rst_busy", busy_w[i], 0);
      check("rst_done", done_w[i], 0);
    end

    dir_q = '{8'h55};
    run_phase(0, 100, 0, -1, 1'b0, fr, dn);
    check("frames_55", fr, 1);

    dir_q = '{8'hA5, 8'h3C, 8'hFF};
    run_phase(0, 300, 0, -1, 1'b1, fr, dn);
    check("frames_full_buf", fr, 2);

    dir_q = '{8'h07};
    run_phase(1, 100, 0, -1, 1'b0, fr, dn);
    check("frames_even", fr, 1);
    dir_q = '{8'h07};
    run_phase(2, 100, 0, -1, 1'b0, fr, dn);
    check("frames_odd", fr, 1);

    dir_q = '{8'hA5, 8'h3C};
    run_phase(3, 300, 0, -1, 1'b1, fr, dn);
    check("frames_sb32", fr, 2);

    dir_q = '{8'h12, 8'h34};
    run_phase(0, 600, 0, 70, 1'b0, fr, dn);
    check("rst_abort_done", dn, 0);

    for (int k = 0; k < NINST; k++) begin
      dir_q.delete();
      run_phase(k, 3000, 1, -1, 1'b0, fr, dn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
